gcd_host_driver: RTL and testbench

GCD_HOST_DRIVER -- requirements
Module: gcd_host_driver

---
 rtl/gcd_host_driver.sv | 187 ++++++++++++++++++
 tb/tb_gcd_host_driver.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_host_driver.sv
// Test sequencer for an external GCD processor: it resets the processor, feeds it
// X then Y, waits for halt and checks moutput against an internal subtract-only GCD.
//
// state | meaning
// IDLE  | waiting for start; rejects zero operands with a one-cycle err
// PRST  | one-cycle proc_reset pulse
// GAP1  | START_GAP idle cycles after the processor reset
// SENDX | enter strobe with minput = X
// GAP2  | OPERAND_GAP idle cycles between operands
// SENDY | enter strobe with minput = Y
// WAIT  | waiting for halt and the internal GCD, bounded by TIMEOUT
// CHECK | compare captured result against the internal GCD
module gcd_host_driver #(
    parameter int START_GAP   = 4,
    parameter int OPERAND_GAP = 7,
    parameter int TIMEOUT     = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] x_in,
    input  logic [7:0] y_in,
    input  logic       halt,
    input  logic [7:0] moutput,
    output logic       proc_reset,
    output logic       enter,
    output logic [7:0] minput,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic       fail,
    output logic       timeout,
    output logic       err,
    output logic [7:0] result,
    output logic [7:0] expected,
    output logic [7:0] pass_count,
    output logic [7:0] fail_count
);

    typedef enum logic [2:0] {IDLE, PRST, GAP1, SENDX, GAP2, SENDY, WAIT, CHECK} state_t;

    localparam logic [15:0] GAP1_LOAD = 16'(START_GAP - 1);
    localparam logic [15:0] GAP2_LOAD = 16'(OPERAND_GAP - 1);
    localparam logic [15:0] WAIT_LOAD = 16'(TIMEOUT - 1);

    state_t      state, state_nx;
    logic [15:0] cnt, cnt_nx;
    logic [7:0]  x_r, y_r, a, b;
    logic        gcd_done, halt_seen, seen;
    logic        accept, reject, tmo_fire, chk_fire;

    // One down-counter is shared by both gaps and the halt wait.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        accept   = 1'b0;
        reject   = 1'b0;
        tmo_fire = 1'b0;
        chk_fire = 1'b0;
        seen     = halt_seen | halt;
        case (state)
            IDLE: begin
                if (start) begin
                    if (x_in != 8'd0 && y_in != 8'd0) begin
                        accept   = 1'b1;
                        state_nx = PRST;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            PRST: begin
                state_nx = GAP1;
                cnt_nx   = GAP1_LOAD;
            end
            GAP1: begin
                if (cnt == 16'd0) state_nx = SENDX;
                else              cnt_nx   = cnt - 16'd1;
            end
            SENDX: begin
                state_nx = GAP2;
                cnt_nx   = GAP2_LOAD;
            end
            GAP2: begin
                if (cnt == 16'd0) state_nx = SENDY;
                else              cnt_nx   = cnt - 16'd1;
            end
            SENDY: begin
                state_nx = WAIT;
                cnt_nx   = WAIT_LOAD;
            end
            WAIT: begin
                if (seen && gcd_done) begin
                    state_nx = CHECK;
                end else if (!seen && cnt == 16'd0) begin
                    state_nx = IDLE;
                    tmo_fire = 1'b1;
                end else if (cnt != 16'd0) begin
                    cnt_nx = cnt - 16'd1;
                end
            end
            CHECK: begin
                state_nx = IDLE;
                chk_fire = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign proc_reset = (state == PRST);
    assign enter      = (state == SENDX) || (state == SENDY);
    assign busy       = (state != IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 16'd0;
            x_r        <= 8'd0;
            y_r        <= 8'd0;
            minput     <= 8'd0;
            halt_seen  <= 1'b0;
            result     <= 8'd0;
            done       <= 1'b0;
            err        <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            timeout    <= 1'b0;
            pass_count <= 8'd0;
            fail_count <= 8'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            err   <= reject;
            done  <= tmo_fire | chk_fire;
            if (state == GAP1 && state_nx == SENDX) minput <= x_r;
            if (state == GAP2 && state_nx == SENDY) minput <= y_r;
            if (accept) begin
                x_r       <= x_in;
                y_r       <= y_in;
                halt_seen <= 1'b0;
                pass      <= 1'b0;
                fail      <= 1'b0;
                timeout   <= 1'b0;
            end
            if (state == WAIT && halt && !halt_seen) begin
                halt_seen <= 1'b1;
                result    <= moutput;
            end
            if (tmo_fire) begin
                timeout <= 1'b1;
                fail    <= 1'b1;
                if (fail_count != 8'hFF) fail_count <= fail_count + 8'd1;
            end
            if (chk_fire) begin
                if (result == expected) begin
                    pass <= 1'b1;
                    if (pass_count != 8'hFF) pass_count <= pass_count + 8'd1;
                end else begin
                    fail <= 1'b1;
                    if (fail_count != 8'hFF) fail_count <= fail_count + 8'd1;
                end
            end
        end
    end

    // Subtractive GCD runs free of the processor handshake.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a        <= 8'd0;
            b        <= 8'd0;
            gcd_done <= 1'b0;
            expected <= 8'd0;
        end else if (accept) begin
            a        <= x_in;
            b        <= y_in;
            gcd_done <= 1'b0;
        end else if (!gcd_done) begin
            if (a > b)      a <= a - b;
            else if (b > a) b <= b - a;
            else begin
                gcd_done <= 1'b1;
                expected <= a;
            end
        end
    end

endmodule

// File: tb/tb_gcd_host_driver.sv
// Bench for gcd_host_driver: a transaction-schedule model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_gcd_host_driver;

    localparam int SG = 4;
    localparam int OG = 7;
    localparam int TO = 1000;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       halt  = 1'b0;
    logic [7:0] x_in = 8'd0, y_in = 8'd0, moutput = 8'd0;
    logic       proc_reset, enter, busy, done, pass, fail, timeout, err;
    logic [7:0] minput, result, expected, pass_count, fail_count;

    gcd_host_driver #(.START_GAP(SG), .OPERAND_GAP(OG), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .start(start), .x_in(x_in), .y_in(y_in),
        .halt(halt), .moutput(moutput), .proc_reset(proc_reset), .enter(enter),
        .minput(minput), .busy(busy), .done(done), .pass(pass), .fail(fail),
        .timeout(timeout), .err(err), .result(result), .expected(expected),
        .pass_count(pass_count), .fail_count(fail_count)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Euclid by division; subtraction count is the sum of quotients minus one.
    function automatic void gcd_ref(input int x, input int y, output int g, output int steps);
        int p, q, r, s;
        p = (x > y) ? x : y;
        q = (x > y) ? y : x;
        s = 0;
        while (q != 0) begin
            s += p / q;
            r = p % q;
            p = q;
            q = r;
        end
        g     = p;
        steps = s - 1;
    endfunction

    // Model: t counts edges since the accepting edge.
    int m_active, m_t, m_x, m_y, m_g, m_steps, m_hs, m_chk, m_res, m_exp;
    int m_pass, m_fail, m_tmo, m_err, m_done, m_pc, m_fc, m_min;

    task automatic model_reset();
        m_active = 0; m_t = 0; m_x = 0; m_y = 0; m_g = 0; m_steps = 0;
        m_hs = 0; m_chk = 0; m_res = 0; m_exp = 0; m_pass = 0; m_fail = 0;
        m_tmo = 0; m_err = 0; m_done = 0; m_pc = 0; m_fc = 0; m_min = 0;
    endtask

    task automatic model_step(input int s_start, input int s_x, input int s_y,
                              input int s_halt, input int s_mout);
        m_err  = 0;
        m_done = 0;
        if (m_active == 0) begin
            if (s_start != 0) begin
                if (s_x != 0 && s_y != 0) begin
                    m_active = 1; m_t = 0; m_x = s_x; m_y = s_y;
                    gcd_ref(s_x, s_y, m_g, m_steps);
                    m_hs = 0; m_chk = 0; m_pass = 0; m_fail = 0; m_tmo = 0;
                end else begin
                    m_err = 1;
                end
            end
        end else begin
            m_t++;
            if (m_t == m_steps + 1) m_exp = m_g;
            if (m_t == SG + 1) m_min = m_x;
            if (m_t == SG + OG + 2) m_min = m_y;
            if (m_chk != 0) begin
                if (m_res == m_exp) begin
                    m_pass = 1;
                    if (m_pc < 255) m_pc++;
                end else begin
                    m_fail = 1;
                    if (m_fc < 255) m_fc++;
                end
                m_done = 1; m_active = 0;
            end else if (m_t >= SG + OG + 4) begin
                if (s_halt != 0 && m_hs == 0) begin
                    m_hs = 1; m_res = s_mout;
                end
                if (m_hs != 0 && m_t >= m_steps + 2) begin
                    m_chk = 1;
                end else if (m_hs == 0 && m_t == SG + OG + 3 + TO) begin
                    m_tmo = 1; m_fail = 1;
                    if (m_fc < 255) m_fc++;
                    m_done = 1; m_active = 0;
                end
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clock);
            if (reset) model_reset();
            else model_step(int'(start), int'(x_in), int'(y_in), int'(halt), int'(moutput));
            @(negedge clock);
            if (reset) model_reset();
            chk("busy", int'(busy), m_active);
            chk("proc_reset", int'(proc_reset), (m_active != 0 && m_t == 0) ? 1 : 0);
            chk("enter", int'(enter),
                (m_active != 0 && (m_t == SG + 1 || m_t == SG + OG + 2)) ? 1 : 0);
            chk("minput", int'(minput), m_min);
            chk("done", int'(done), m_done);
            chk("err", int'(err), m_err);
            chk("pass", int'(pass), m_pass);
            chk("fail", int'(fail), m_fail);
            chk("timeout", int'(timeout), m_tmo);
            chk("result", int'(result), m_res);
            chk("expected", int'(expected), m_exp);
            chk("pass_count", int'(pass_count), m_pc);
            chk("fail_count", int'(fail_count), m_fc);
        end
    end

    // hd < 0: never raise halt; otherwise halt is first sampled hd edges into WAIT.
    task automatic run_txn(input int x, input int y, input int mo, input int hd, input bit poke,
                           output int lat, output int nd, output int ne,
                           output int e1, output int e2);
        int n;
        bit fin;
        n = 0; fin = 0; lat = -1; nd = 0; ne = 0; e1 = -1; e2 = -1;
        @(posedge clock);
        #1 start = 1'b1; x_in = 8'(x); y_in = 8'(y); moutput = 8'(mo); halt = 1'b0;
        @(posedge clock);
        #1 start = 1'b0;
        while (!fin && n < 3000) begin
            @(negedge clock);
            if (enter) begin
                ne++;
                if (e1 < 0) e1 = n; else e2 = n;
            end
            if (done) begin
                fin = 1'b1; lat = n; nd++;
            end else begin
                @(posedge clock);
                n++;
                #1;
                start = poke && (n == 9);
                halt  = (hd >= 0) && (n >= SG + OG + 3 + hd);
            end
        end
        halt = 1'b0;
        if (!fin) chk("txn_finished", 0, 1);
        repeat (3) begin
            @(negedge clock);
            if (done) nd++;
            if (enter) ne++;
        end
    endtask

    task automatic err_txn(input int x, input int y);
        @(posedge clock);
        #1 start = 1'b1; x_in = 8'(x); y_in = 8'(y);
        @(posedge clock);
        #1 start = 1'b0;
        @(negedge clock);
        chk("err_pulse", int'(err), 1);
        chk("err_busy", int'(busy), 0);
        chk("err_enter", int'(enter), 0);
        @(negedge clock);
        chk("err_single", int'(err), 0);
        chk("err_busy2", int'(busy), 0);
    endtask

    initial begin
        int lat, nd, ne, e1, e2, g, s, mo, hd, v;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_busy", int'(busy), 0);
        chk("rst_minput", int'(minput), 0);
        chk("rst_pc", int'(pass_count), 0);

        run_txn(12, 18, 6, 3, 0, lat, nd, ne, e1, e2);
        chk("t12_18_lat", lat, 19);
        chk("t12_18_pass", int'(pass), 1);
        chk("t12_18_pc", int'(pass_count), 1);
        chk("t12_18_exp", int'(expected), 6);
        chk("t12_18_ndone", nd, 1);
        chk("t12_18_nenter", ne, 2);

        run_txn(7, 7, 3, 0, 0, lat, nd, ne, e1, e2);
        chk("t7_7_lat", lat, 16);
        chk("t7_7_fail", int'(fail), 1);
        chk("t7_7_fc", int'(fail_count), 1);
        chk("t7_7_tmo", int'(timeout), 0);
        chk("t7_7_exp", int'(expected), 7);

        run_txn(100, 45, 0, -1, 0, lat, nd, ne, e1, e2);
        chk("tmo_lat", lat, 14 + TO);
        chk("tmo_flag", int'(timeout), 1);
        chk("tmo_fail", int'(fail), 1);
        chk("tmo_fc", int'(fail_count), 2);

        err_txn(0, 9);

        run_txn(33, 22, 11, 5, 1, lat, nd, ne, e1, e2);
        chk("poke_e1", e1, 5);
        chk("poke_e2", e2, 13);
        chk("poke_ne", ne, 2);
        chk("poke_pass", int'(pass), 1);

        run_txn(255, 1, 1, 0, 0, lat, nd, ne, e1, e2);
        chk("t255_1_lat", lat, 257);
        chk("t255_1_exp", int'(expected), 1);

        @(posedge clock);
        #1 start = 1'b1; x_in = 8'd50; y_in = 8'd20;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (9) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_enter", int'(enter), 0);
        chk("arst_minput", int'(minput), 0);
        chk("arst_pc", int'(pass_count), 0);
        chk("arst_fc", int'(fail_count), 0);
        chk("arst_exp", int'(expected), 0);
        chk("arst_result", int'(result), 0);
        @(posedge clock);
        #1 reset = 1'b0;
        run_txn(1, 127, 1, 0, 0, lat, nd, ne, e1, e2);
        chk("t1_127_pass", int'(pass), 1);
        chk("t1_127_pc", int'(pass_count), 1);

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                err_txn($urandom_range(0, 1) != 0 ? 0 : $urandom_range(1, 255), 0);
            end else begin
                v  = $urandom_range(1, 255);
                s  = $urandom_range(1, 255);
                gcd_ref(v, s, g, lat);
                mo = ($urandom_range(0, 1) != 0) ? g : $urandom_range(0, 255);
                hd = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 300);
                run_txn(v, s, mo, hd, $urandom_range(0, 1) != 0, lat, nd, ne, e1, e2);
                chk("rand_ndone", nd, 1);
            end
        end

        for (int i = 0; i < 260; i++) begin
            v = $urandom_range(1, 255);
            run_txn(v, v, v, 0, 0, lat, nd, ne, e1, e2);
        end
        chk("sat_pc", int'(pass_count), 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
